// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one 4-bit ALU between two requesters.
// Executes one operation at a time and returns result and flags on a registered response channel.
module alu_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_cf,
    output logic             rsp_of,
    output logic             rsp_zf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    state_t           state_r;
    state_t           state_next_s;
    logic             last_grant_r;
    logic             grant_any_s;
    logic             grant_id_s;
    logic             accept_s;
    logic [2:0]       sel_op_s;
    logic [WIDTH-1:0] sel_a_s;
    logic [WIDTH-1:0] sel_b_s;

    logic [2:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             id_r;

    logic [WIDTH-1:0] alu_y_s;
    logic             alu_cf_s;
    logic             alu_of_s;
    logic             alu_zf_s;

    logic             rsp_valid_r;
    logic             rsp_id_r;
    logic [WIDTH-1:0] rsp_y_r;
    logic             rsp_cf_r;
    logic             rsp_of_r;
    logic             rsp_zf_r;

    // Packed result {cf, of, zf, y}; undefined opcodes fall to y=0 so zf reads 1.
    function automatic logic [WIDTH+2:0] alu_eval(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH:0]   ext;
        logic [WIDTH-1:0] y;
        logic             cf;
        logic             of;
        ext = {(WIDTH+1){1'b0}};
        y   = {WIDTH{1'b0}};
        cf  = 1'b0;
        of  = 1'b0;
        case (op)
            OP_ADD: begin
                ext = {1'b0, a} + {1'b0, b};
                y   = ext[WIDTH-1:0];
                cf  = ext[WIDTH];
                of  = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                ext = {1'b0, a} - {1'b0, b};
                y   = ext[WIDTH-1:0];
                cf  = ext[WIDTH];
                of  = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOT:  y = ~a;
            default: y = {WIDTH{1'b0}};
        endcase
        return {cf, of, (y == {WIDTH{1'b0}}), y};
    endfunction

    // Round-robin grant: on a tie the requester that was not served last wins.
    always_comb begin
        grant_any_s = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id_s = ~last_grant_r;
        end else if (req1_valid) begin
            grant_id_s = 1'b1;
        end else begin
            grant_id_s = 1'b0;
        end
    end

    // Payload of the currently granted requester.
    always_comb begin
        if (grant_id_s) begin
            sel_op_s = req1_op;
            sel_a_s  = req1_a;
            sel_b_s  = req1_b;
        end else begin
            sel_op_s = req0_op;
            sel_a_s  = req0_a;
            sel_b_s  = req0_b;
        end
    end

    assign accept_s = (state_r == IDLE) && grant_any_s;

    // ALU driven only by the latched operation.
    always_comb begin
        {alu_cf_s, alu_of_s, alu_zf_s, alu_y_s} = alu_eval(op_r, a_r, b_r);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_any_s) begin
                    state_next_s = EXEC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            EXEC: state_next_s = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Ready outputs: only in IDLE and never while reset is asserted.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_r)
            IDLE: begin
                if (!rst && grant_any_s) begin
                    req0_ready = ~grant_id_s;
                    req1_ready = grant_id_s;
                end else begin
                    req0_ready = 1'b0;
                    req1_ready = 1'b0;
                end
            end
            default: begin
                req0_ready = 1'b0;
                req1_ready = 1'b0;
            end
        endcase
    end

    // Operation latch and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= 1'b1;
            op_r         <= 3'b000;
            a_r          <= {WIDTH{1'b0}};
            b_r          <= {WIDTH{1'b0}};
            id_r         <= 1'b0;
        end else if (accept_s) begin
            last_grant_r <= grant_id_s;
            op_r         <= sel_op_s;
            a_r          <= sel_a_s;
            b_r          <= sel_b_s;
            id_r         <= grant_id_s;
        end
    end

    // Response registers: loaded on the EXEC->RESP edge, valid cleared on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= 1'b0;
            rsp_y_r     <= {WIDTH{1'b0}};
            rsp_cf_r    <= 1'b0;
            rsp_of_r    <= 1'b0;
            rsp_zf_r    <= 1'b0;
        end else if (state_r == EXEC) begin
            rsp_valid_r <= 1'b1;
            rsp_id_r    <= id_r;
            rsp_y_r     <= alu_y_s;
            rsp_cf_r    <= alu_cf_s;
            rsp_of_r    <= alu_of_s;
            rsp_zf_r    <= alu_zf_s;
        end else if ((state_r == RESP) && rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_y     = rsp_y_r;
    assign rsp_cf    = rsp_cf_r;
    assign rsp_of    = rsp_of_r;
    assign rsp_zf    = rsp_zf_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter: ALU results, handshake timing,
// round-robin ties, backpressure and reset in the middle of an operation.
module tb_alu_arbiter;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] UND = 3'b010;
    localparam logic [2:0] AND = 3'b100;
    localparam logic [2:0] OR  = 3'b101;
    localparam logic [2:0] XOR = 3'b110;
    localparam logic [2:0] NOT = 3'b111;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0] req0_op, req1_op;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_cf, rsp_of, rsp_zf;
    logic [3:0] rsp_y;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_y(rsp_y), .rsp_cf(rsp_cf), .rsp_of(rsp_of), .rsp_zf(rsp_zf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_rsp(input string tag, input logic id, input logic [3:0] y,
                             input logic cf, input logic of, input logic zf);
        chk({tag, "_valid"}, {7'd0, rsp_valid}, 8'd1);
        chk({tag, "_id"},    {7'd0, rsp_id},    {7'd0, id});
        chk({tag, "_y"},     {4'd0, rsp_y},     {4'd0, y});
        chk({tag, "_flags"}, {5'd0, rsp_cf, rsp_of, rsp_zf}, {5'd0, cf, of, zf});
    endtask

    // Called at a negedge in IDLE; returns at a negedge back in IDLE.
    task automatic do_op(input string tag, input logic id, input logic [2:0] op,
                         input logic [3:0] a, input logic [3:0] b, input logic [3:0] ey,
                         input logic ecf, input logic eof, input logic ezf);
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
        #1;
        chk({tag, "_rdy"}, {6'd0, req1_ready, req0_ready}, id ? 8'd2 : 8'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk({tag, "_exec"}, {5'd0, rsp_valid, req1_ready, req0_ready}, 8'd0);
        @(negedge clk);
        check_rsp(tag, id, ey, ecf, eof, ezf);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_done"}, {7'd0, rsp_valid}, 8'd0);
    endtask

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = ADD; req0_a = 4'd0; req0_b = 4'd0;
        req1_valid = 1'b1; req1_op = ADD; req1_a = 4'd0; req1_b = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {6'd0, req1_ready, req0_ready}, 8'd0);
        chk("rst_valid", {7'd0, rsp_valid}, 8'd0);
        chk("rst_rsp", {1'b0, rsp_id, rsp_y, rsp_cf, rsp_of, rsp_zf}, 8'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        do_op("add_7_9", 1'b0, ADD, 4'd7, 4'd9, 4'd0,  1'b1, 1'b0, 1'b1);
        do_op("add_7_1", 1'b1, ADD, 4'd7, 4'd1, 4'd8,  1'b0, 1'b1, 1'b0);
        do_op("sub_3_5", 1'b1, SUB, 4'd3, 4'd5, 4'd14, 1'b1, 1'b0, 1'b0);
        do_op("sub_8_1", 1'b0, SUB, 4'd8, 4'd1, 4'd7,  1'b0, 1'b1, 1'b0);
        do_op("not_5",   1'b0, NOT, 4'd5, 4'd3, 4'd10, 1'b0, 1'b0, 1'b0);
        do_op("undef",   1'b1, UND, 4'd5, 4'd3, 4'd0,  1'b0, 1'b0, 1'b1);
        do_op("or_c_3",  1'b1, OR,  4'hC, 4'h3, 4'hF,  1'b0, 1'b0, 1'b0);
        do_op("xor_eq",  1'b0, XOR, 4'h6, 4'h6, 4'h0,  1'b0, 1'b0, 1'b1);
        do_op("sub_eq",  1'b1, SUB, 4'd9, 4'd9, 4'd0,  1'b0, 1'b0, 1'b1);

        // Backpressure: response held while rsp_ready is low, inputs ignored.
        req0_valid = 1'b1; req0_op = AND; req0_a = 4'hC; req0_b = 4'hA;
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = OR; req1_a = 4'hC; req1_b = 4'h3;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check_rsp("bp_hold", 1'b0, 4'h8, 1'b0, 1'b0, 1'b0);
            chk("bp_ready", {6'd0, req1_ready, req0_ready}, 8'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", {7'd0, rsp_valid}, 8'd0);
        chk("bp_next_grant", {6'd0, req1_ready, req0_ready}, 8'd2);
        @(negedge clk);
        req1_valid = 1'b0;
        chk("bp_next_exec", {7'd0, rsp_valid}, 8'd0);
        @(negedge clk);
        check_rsp("bp_next", 1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_next_done", {7'd0, rsp_valid}, 8'd0);

        // Reset during EXEC after serving req0: discarded, pointer restored.
        req0_valid = 1'b1; req0_op = ADD; req0_a = 4'd1; req0_b = 4'd1;
        @(negedge clk);
        req0_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rexec_valid0", {7'd0, rsp_valid}, 8'd0);
        chk("rexec_rsp", {1'b0, rsp_id, rsp_y, rsp_cf, rsp_of, rsp_zf}, 8'd0);
        @(negedge clk);
        chk("rexec_valid1", {7'd0, rsp_valid}, 8'd0);

        // Tie: both valid continuously, strict alternation starting at req0.
        req0_valid = 1'b1; req0_op = ADD; req0_a = 4'd1; req0_b = 4'd1;
        req1_valid = 1'b1; req1_op = XOR; req1_a = 4'hF; req1_b = 4'h3;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("tie_grant", {6'd0, req1_ready, req0_ready}, (i % 2 == 0) ? 8'd1 : 8'd2);
            @(negedge clk);
            chk("tie_exec", {6'd0, req1_ready, req0_ready}, 8'd0);
            @(negedge clk);
            check_rsp("tie_rsp", (i % 2 == 1), (i % 2 == 1) ? 4'hC : 4'h2, 1'b0, 1'b0, 1'b0);
            chk("tie_resp_rdy", {6'd0, req1_ready, req0_ready}, 8'd0);
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares one ALU instance between two independent requesters. Each requester submits an operation (opcode plus two operands) over a valid/ready handshake. The block executes one operation at a time and returns the result and flags on a shared response channel with backpressure. It sits between datapath clients, such as sequence generators and test harnesses, and the single ALU.

## Interface
- WIDTH, 4, operand/result width in bits (the ALU is 4-bit; only 4 is supported).
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle (when valid && ready).
- req0_op  in  3  requester 0 opcode.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1.
- rsp_valid  out  1  response holding valid data.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  index of the requester that issued the operation.
- rsp_y  out  WIDTH  result.
- rsp_cf, rsp_of, rsp_zf  out  1  carry/borrow, signed overflow, zero flags.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - Compute grant from the valid inputs and the last_grant pointer.
  - If exactly one requester is valid, grant it.
  - If both are valid, grant the requester that is not last_grant.
  - req*_ready = (state==IDLE) && granted. Ready is combinational; it is low for both requesters outside IDLE.
  - On handshake: latch op, a, b and the id; set last_grant=id; go to EXEC.
- EXEC:
  - The latched operands drive the ALU.
  - At the clock edge, capture y and the flags into the response registers; go to RESP.
- RESP:
  - rsp_valid=1. The response registers are held stable.
  - On rsp_valid && rsp_ready at the edge, go to IDLE. No new request is accepted in the same cycle.
- Opcode semantics, modulo 2^WIDTH:
  - 000 add: y=a+b. cf=carry out. of=signed overflow (operands share a sign and the result sign differs).
  - 001 sub: y=a-b. cf=1 iff a<b unsigned (borrow). of=signed overflow (operand signs differ and the result sign differs from a).
  - 100 and: y=a&b.
  - 101 or: y=a|b.
  - 110 xor: y=a^b.
  - 111 not: y=~a, b ignored.
  - For 100, 101, 110 and 111: cf=of=0.
  - Undefined opcodes (010, 011): y=0, cf=of=0, zf=1.
  - For every opcode: zf=(y==0).
- Boundary behaviour:
  - Simultaneous valid from both requesters: alternate strictly, so neither requester starves.
  - A requester that drops valid before being accepted is simply not granted; the pointer is unchanged.
  - Reset at any state:
    - The in-flight operation is discarded without a response.
    - State=IDLE, last_grant=1, so requester 0 has priority on the first tie.
  - Inputs are ignored outside IDLE; a requester must hold its payload stable while valid && !ready.

## Timing
- Reset values: rsp_valid=0, rsp_id=0, rsp_y=0, rsp_cf=0, rsp_of=0, rsp_zf=0, req0_ready=0 and req1_ready=0 during reset cycles.
- Handshake sampled at edge E0 → state EXEC in cycle 1 → result registered at E1 → rsp_valid=1 from cycle 2.
- Latency: two cycles from acceptance to rsp_valid.
- Minimum issue interval: 3 cycles (accept, exec, response accepted with rsp_ready held high).
- With rsp_ready low, RESP persists indefinitely with all rsp_* constant.
- rsp_* change only on the EXEC→RESP edge or on reset.

## Test plan
- Reset, then req0: op 000, a=7, b=9 → after 2 cycles rsp_id=0, y=0, cf=1, of=0, zf=1.
- req1: op 000, a=7, b=1 → y=8, cf=0, of=1, zf=0. Then op 001, a=3, b=5 → y=14, cf=1, of=0.
- op 001, a=8, b=1 → y=7, cf=0, of=1. Then op 111, a=5 → y=10, cf=of=zf=0. Then op 010 → y=0, zf=1.
- Both valid continuously for 4 operations after reset → grants 0,1,0,1, with ready pulsing one requester at a time.
- Hold rsp_ready=0 for 5 cycles in RESP → rsp_* stable, both readys 0. Raise rsp_ready → IDLE the next cycle, then the next grant.
- Assert rst during EXEC → no response appears, rsp_valid=0. After release, a tie grants req0 first.
